bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin_to_bcd_seq_pkg.sv | 11 +
 rtl/bcd_add3_digit.sv | 7 +
 rtl/bin_to_bcd_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: display constants and converter state encoding, shared with the 7-segment driver
package bin_to_bcd_seq_pkg;
    localparam int SEG_DIGITS  = 4;
    localparam int BCD_W       = 4 * SEG_DIGITS;
    localparam int MAX_DISPLAY = 9999;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble correction for one BCD nibble
module bcd_add3_digit (
    input  logic [3:0] in_i,
    output logic [3:0] out_o
);
    always_comb out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: shift-and-add-3 binary to BCD, one bit per clock, result held between conversions
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W    = 14,
    parameter int DIGITS  = SEG_DIGITS,
    parameter int MAX_VAL = MAX_DISPLAY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    localparam int SR_W  = 4 * DIGITS + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [IN_W-1:0] MAX_V = IN_W'(MAX_VAL);

    state_e              state_q;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q, done_q, ovf_q, ovfp_q;
    logic [4*DIGITS-1:0] bcd_q, adj;
    logic [IN_W-1:0]     operand;
    logic                ovf_in;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        bcd_add3_digit u_add3 (
            .in_i (sr_q[IN_W+4*d +: 4]),
            .out_o(adj[4*d +: 4])
        );
    end

    always_comb begin
        ovf_in  = bin > MAX_V;
        operand = ovf_in ? MAX_V : bin;
        sr_d    = {adj, sr_q[IN_W-1:0]} << 1;
    end

    // bcd/ovf only load on the final shift so the display never sees partial digits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            ovfp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sr_q    <= {{(4*DIGITS){1'b0}}, operand};
                        ovfp_q  <= ovf_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(IN_W - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= sr_d[SR_W-1 -: 4*DIGITS];
                        ovf_q   <= ovfp_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
endmodule
